// File: rtl/bist_mm_req_ctrl_pkg.sv
// Shared definitions for the BIST host->MM request controller: state encoding,
// timeout tag and error-log counter width.
package bist_mm_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_HOLD = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    localparam logic [15:0] TO_TAG    = 16'hDEAD;
    localparam int          ERR_CNT_W = 16;

endpackage

// File: rtl/bist_mm_req_ctrl_if.sv
// Host request/response and MM decoder signals of bist_mm_req_ctrl.
// Optional error-log signals are present when BIST_MM_ERR_LOG_EN is defined.
interface bist_mm_req_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64
);
    import bist_mm_pkg::*;

    logic              iHOST_REQ_V;
    logic              oHOST_REQ_RDY;
    logic              iHOST_WR;
    logic [ADDR_W-1:0] iHOST_ADDR;
    logic [DATA_W-1:0] iHOST_WR_DATA;
    logic              oHOST_RSP_V;
    logic [DATA_W-1:0] oHOST_RSP_DATA;
    logic              oHOST_RSP_ERR;
    logic              oMM_WR_EN;
    logic              oMM_RD_EN;
    logic [ADDR_W-1:0] oMM_ADDR;
    logic [DATA_W-1:0] oMM_WR_DATA;
    logic [DATA_W-1:0] iMM_RD_DATA;
    logic              iMM_RD_DATA_V;
`ifdef BIST_MM_ERR_LOG_EN
    logic                 iERR_CLR;
    logic [ERR_CNT_W-1:0] oERR_TO_CNT;
    logic [ERR_CNT_W-1:0] oERR_STRAY_CNT;
    logic [ADDR_W-1:0]    oERR_LAST_ADDR;
`endif

    modport slave (
        input  iHOST_REQ_V, iHOST_WR, iHOST_ADDR, iHOST_WR_DATA,
        input  iMM_RD_DATA, iMM_RD_DATA_V,
`ifdef BIST_MM_ERR_LOG_EN
        input  iERR_CLR,
        output oERR_TO_CNT, oERR_STRAY_CNT, oERR_LAST_ADDR,
`endif
        output oHOST_REQ_RDY, oHOST_RSP_V, oHOST_RSP_DATA, oHOST_RSP_ERR,
        output oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA
    );

    modport master (
        output iHOST_REQ_V, iHOST_WR, iHOST_ADDR, iHOST_WR_DATA,
        output iMM_RD_DATA, iMM_RD_DATA_V,
`ifdef BIST_MM_ERR_LOG_EN
        output iERR_CLR,
        input  oERR_TO_CNT, oERR_STRAY_CNT, oERR_LAST_ADDR,
`endif
        input  oHOST_REQ_RDY, oHOST_RSP_V, oHOST_RSP_DATA, oHOST_RSP_ERR,
        input  oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA
    );

endinterface

// File: rtl/bist_mm_req_ctrl.sv
// Single-outstanding host->MM request controller feeding bist_addr_decoder.
// Define BIST_MM_ERR_LOG_EN to add the timeout/stray error log.
module bist_mm_req_ctrl
    import bist_mm_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024,
    parameter int WR_GAP  = 8
) (
    input  logic               clk,
    input  logic               rst,
    bist_mm_req_ctrl_if.slave  bus
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_GAP - 1);

    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_ISSUE   = S_ISSUE;
    localparam logic [2:0] ST_RD_WAIT = S_RD_WAIT;
    localparam logic [2:0] ST_WR_HOLD = S_WR_HOLD;
    localparam logic [2:0] ST_RESP    = S_RESP;

    // Timeout response: tag in the top 16 bits, request address in the low bits.
    function automatic logic [DATA_W-1:0] timeout_pattern(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] pat;
        pat = {DATA_W{1'b0}};
        pat[ADDR_W-1:0] = addr;
        pat[DATA_W-1 -: 16] = TO_TAG;
        return pat;
    endfunction

    logic [2:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              wr_r;
    logic              rdy_r;
    logic              wr_en_r;
    logic              rd_en_r;
    logic [ADDR_W-1:0] mm_addr_r;
    logic [DATA_W-1:0] mm_wr_data_r;
    logic              rsp_v_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_err_r;

    logic accept_s;
    logic rd_hit_s;
    logic rd_to_s;

    assign accept_s = (state_r == ST_IDLE) && rdy_r && bus.iHOST_REQ_V;
    assign rd_hit_s = (state_r == ST_RD_WAIT) && bus.iMM_RD_DATA_V;
    // Returning data in the final wait cycle takes priority over the timeout.
    assign rd_to_s  = (state_r == ST_RD_WAIT) && !bus.iMM_RD_DATA_V && (cnt_r == TO_LAST);

    // Request sequencing FSM with registered handshake, pulse and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            wr_r         <= 1'b0;
            rdy_r        <= 1'b0;
            wr_en_r      <= 1'b0;
            rd_en_r      <= 1'b0;
            mm_addr_r    <= {ADDR_W{1'b0}};
            mm_wr_data_r <= {DATA_W{1'b0}};
            rsp_v_r      <= 1'b0;
            rsp_data_r   <= {DATA_W{1'b0}};
            rsp_err_r    <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            rd_en_r <= 1'b0;
            rsp_v_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r      <= ST_ISSUE;
                        rdy_r        <= 1'b0;
                        wr_r         <= bus.iHOST_WR;
                        wr_en_r      <= bus.iHOST_WR;
                        rd_en_r      <= !bus.iHOST_WR;
                        mm_addr_r    <= bus.iHOST_ADDR;
                        mm_wr_data_r <= bus.iHOST_WR_DATA;
                    end else begin
                        rdy_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= wr_r ? ST_WR_HOLD : ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (rd_hit_s) begin
                        rsp_v_r    <= 1'b1;
                        rsp_data_r <= bus.iMM_RD_DATA;
                        rsp_err_r  <= 1'b0;
                        state_r    <= ST_RESP;
                    end else if (rd_to_s) begin
                        rsp_v_r    <= 1'b1;
                        rsp_data_r <= timeout_pattern(mm_addr_r);
                        rsp_err_r  <= 1'b1;
                        state_r    <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WR_HOLD: begin
                    if (cnt_r == WR_LAST) begin
                        rsp_v_r    <= 1'b1;
                        rsp_data_r <= {DATA_W{1'b0}};
                        rsp_err_r  <= 1'b0;
                        state_r    <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    rdy_r   <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rdy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oHOST_REQ_RDY  = rdy_r;
    assign bus.oHOST_RSP_V    = rsp_v_r;
    assign bus.oHOST_RSP_DATA = rsp_data_r;
    assign bus.oHOST_RSP_ERR  = rsp_err_r;
    assign bus.oMM_WR_EN      = wr_en_r;
    assign bus.oMM_RD_EN      = rd_en_r;
    assign bus.oMM_ADDR       = mm_addr_r;
    assign bus.oMM_WR_DATA    = mm_wr_data_r;

`ifdef BIST_MM_ERR_LOG_EN
    logic                 stray_s;
    logic [ERR_CNT_W-1:0] to_cnt_r;
    logic [ERR_CNT_W-1:0] stray_cnt_r;
    logic [ADDR_W-1:0]    last_addr_r;

    assign stray_s = bus.iMM_RD_DATA_V && (state_r != ST_RD_WAIT);

    // Saturating error log; a clear in the same cycle as an event wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r    <= {ERR_CNT_W{1'b0}};
            stray_cnt_r <= {ERR_CNT_W{1'b0}};
            last_addr_r <= {ADDR_W{1'b0}};
        end else if (bus.iERR_CLR) begin
            to_cnt_r    <= {ERR_CNT_W{1'b0}};
            stray_cnt_r <= {ERR_CNT_W{1'b0}};
            last_addr_r <= {ADDR_W{1'b0}};
        end else begin
            if (rd_to_s) begin
                last_addr_r <= mm_addr_r;
                if (to_cnt_r != {ERR_CNT_W{1'b1}}) begin
                    to_cnt_r <= to_cnt_r + ERR_CNT_W'(1);
                end
            end
            if (stray_s && (stray_cnt_r != {ERR_CNT_W{1'b1}})) begin
                stray_cnt_r <= stray_cnt_r + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.oERR_TO_CNT    = to_cnt_r;
    assign bus.oERR_STRAY_CNT = stray_cnt_r;
    assign bus.oERR_LAST_ADDR = last_addr_r;
`endif

endmodule

// File: tb/tb_bist_mm_req_ctrl.sv
// Randomized self-checking bench for bist_mm_req_ctrl against a cycle-stamped
// transaction model; also covers BIST_MM_ERR_LOG_EN when defined.
module tb_bist_mm_req_ctrl;

    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 32;
    localparam int WR_GAP  = 8;
    localparam int BIG     = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bist_mm_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bist_mm_req_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .WR_GAP (WR_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transaction model: everything is keyed on cycle numbers.
    int          ready_from = BIG;
    int          t_acc      = -10;
    int          resp_cyc   = -10;
    bit          pend_rd    = 1'b0;
    bit          in_reset   = 1'b1;
    bit          m_wr       = 1'b0;
    logic [16:0] m_addr     = '0;
    logic [63:0] m_wdata    = '0;
    logic [63:0] nxt_data   = '0;
    bit          nxt_err    = 1'b0;

    bit          exp_rdy = 1'b0, exp_wr_en = 1'b0, exp_rd_en = 1'b0, exp_rsp_v = 1'b0, exp_rsp_err = 1'b0;
    logic [63:0] exp_rsp_data = '0, exp_wdata = '0;
    logic [16:0] exp_addr = '0;
`ifdef BIST_MM_ERR_LOG_EN
    logic        err_clr = 1'b0;
    logic [15:0] exp_to_cnt = '0, exp_stray_cnt = '0;
    logic [16:0] exp_last_addr = '0;
`endif

    // Observations used by the hand-computed directed checks.
    int          obs_rsp_n, obs_rsp_cyc, obs_rd_n, obs_wr_n, obs_en_first, obs_en_last;
    logic [63:0] obs_rsp_data, obs_en_data;
    logic        obs_rsp_err;
    logic [16:0] obs_en_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rdy",      64'(bus.oHOST_REQ_RDY),  64'(exp_rdy));
        chk("wr_en",    64'(bus.oMM_WR_EN),      64'(exp_wr_en));
        chk("rd_en",    64'(bus.oMM_RD_EN),      64'(exp_rd_en));
        chk("rsp_v",    64'(bus.oHOST_RSP_V),    64'(exp_rsp_v));
        chk("rsp_data", bus.oHOST_RSP_DATA,      exp_rsp_data);
        chk("rsp_err",  64'(bus.oHOST_RSP_ERR),  64'(exp_rsp_err));
        chk("mm_addr",  64'(bus.oMM_ADDR),       64'(exp_addr));
        chk("mm_wdata", bus.oMM_WR_DATA,         exp_wdata);
`ifdef BIST_MM_ERR_LOG_EN
        chk("to_cnt",    64'(bus.oERR_TO_CNT),    64'(exp_to_cnt));
        chk("stray_cnt", 64'(bus.oERR_STRAY_CNT), 64'(exp_stray_cnt));
        chk("last_addr", 64'(bus.oERR_LAST_ADDR), 64'(exp_last_addr));
`endif
    endtask

    // Consume this cycle's inputs; produce the expected outputs of the next cycle.
    task automatic model_step();
        bit dv, to_evt, stray_evt;
        dv = bus.iMM_RD_DATA_V;
        to_evt = 1'b0;
        stray_evt = 1'b0;
        if (rst) begin
            in_reset = 1'b1; ready_from = BIG; t_acc = -10; resp_cyc = -10; pend_rd = 1'b0;
            m_addr = '0; m_wdata = '0;
            exp_rdy = 1'b0; exp_wr_en = 1'b0; exp_rd_en = 1'b0; exp_rsp_v = 1'b0;
            exp_rsp_err = 1'b0; exp_rsp_data = '0; exp_addr = '0; exp_wdata = '0;
`ifdef BIST_MM_ERR_LOG_EN
            exp_to_cnt = '0; exp_stray_cnt = '0; exp_last_addr = '0;
`endif
        end else begin
            if (in_reset) begin
                in_reset = 1'b0;
                ready_from = cyc + 1;
            end
            if (pend_rd && cyc >= t_acc + 2) begin
                if (dv) begin
                    nxt_data = bus.iMM_RD_DATA; nxt_err = 1'b0; pend_rd = 1'b0;
                end else if (cyc == t_acc + TIMEOUT + 1) begin
                    nxt_data = (64'hDEAD << 48) | 64'(m_addr); nxt_err = 1'b1;
                    pend_rd = 1'b0; to_evt = 1'b1;
                end
                if (!pend_rd) begin
                    resp_cyc = cyc + 1;
                    ready_from = cyc + 2;
                end
            end else if (dv) begin
                stray_evt = 1'b1;
            end
`ifdef BIST_MM_ERR_LOG_EN
            if (err_clr) begin
                exp_to_cnt = '0; exp_stray_cnt = '0; exp_last_addr = '0;
            end else begin
                if (to_evt) begin
                    exp_last_addr = m_addr;
                    if (exp_to_cnt != 16'hFFFF) exp_to_cnt++;
                end
                if (stray_evt && exp_stray_cnt != 16'hFFFF) exp_stray_cnt++;
            end
`endif
            if (bus.iHOST_REQ_V && cyc >= ready_from) begin
                t_acc = cyc; m_wr = bus.iHOST_WR; m_addr = bus.iHOST_ADDR; m_wdata = bus.iHOST_WR_DATA;
                if (m_wr) begin
                    resp_cyc = cyc + 2 + WR_GAP; ready_from = resp_cyc + 1;
                    nxt_data = '0; nxt_err = 1'b0;
                end else begin
                    pend_rd = 1'b1; ready_from = BIG;
                end
            end
            exp_rdy   = (cyc + 1 >= ready_from);
            exp_wr_en = (t_acc == cyc) && m_wr;
            exp_rd_en = (t_acc == cyc) && !m_wr;
            exp_rsp_v = (resp_cyc == cyc + 1);
            if (exp_rsp_v) begin
                exp_rsp_data = nxt_data; exp_rsp_err = nxt_err;
            end
            exp_addr = m_addr; exp_wdata = m_wdata;
        end
    endtask

    task automatic tick(input bit rv, input bit wr, input logic [16:0] a, input logic [63:0] wd,
                        input bit dv, input logic [63:0] rd);
        bus.iHOST_REQ_V = rv; bus.iHOST_WR = wr; bus.iHOST_ADDR = a; bus.iHOST_WR_DATA = wd;
        bus.iMM_RD_DATA_V = dv; bus.iMM_RD_DATA = rd;
`ifdef BIST_MM_ERR_LOG_EN
        bus.iERR_CLR = err_clr;
`endif
        model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (bus.oHOST_RSP_V) begin
            obs_rsp_n++; obs_rsp_cyc = cyc; obs_rsp_data = bus.oHOST_RSP_DATA; obs_rsp_err = bus.oHOST_RSP_ERR;
        end
        if (bus.oMM_RD_EN) obs_rd_n++;
        if (bus.oMM_WR_EN) begin
            obs_wr_n++;
            if (obs_en_first < 0) obs_en_first = cyc;
            obs_en_last = cyc; obs_en_addr = bus.oMM_ADDR; obs_en_data = bus.oMM_WR_DATA;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 17'h0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic obs_clear();
        obs_rsp_n = 0; obs_rsp_cyc = -1; obs_rd_n = 0; obs_wr_n = 0; obs_en_first = -1; obs_en_last = -1;
        obs_rsp_data = '0; obs_rsp_err = 1'b0; obs_en_addr = '0; obs_en_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic random_phase(input int n, input int dv_mod);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            else rst = 1'b0;
`ifdef BIST_MM_ERR_LOG_EN
            err_clr = ($urandom_range(0, 49) == 0);
`endif
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 17'($urandom), {$urandom, $urandom},
                 $urandom_range(0, dv_mod - 1) == 0, {$urandom, $urandom});
        end
        rst = 1'b0;
`ifdef BIST_MM_ERR_LOG_EN
        err_clr = 1'b0;
`endif
        idle(TIMEOUT + 4);
    endtask

    int a_c;

    initial begin
        bus.iHOST_REQ_V = 1'b0; bus.iHOST_WR = 1'b0; bus.iHOST_ADDR = '0; bus.iHOST_WR_DATA = '0;
        bus.iMM_RD_DATA_V = 1'b0; bus.iMM_RD_DATA = '0;
`ifdef BIST_MM_ERR_LOG_EN
        bus.iERR_CLR = 1'b0;
`endif
        obs_clear();
        @(negedge clk);
        check_outputs();
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("rdy_after_reset", 64'(bus.oHOST_REQ_RDY), 64'h1);

        // Read with data returned five cycles after accept.
        obs_clear(); a_c = cyc;
        tick(1'b1, 1'b0, 17'h04010, 64'h0, 1'b0, 64'h0);
        idle(4);
        tick(1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h1234);
        idle(3);
        chk("rd_latency", 64'(obs_rsp_cyc - a_c), 64'd6);
        chk("rd_data",    obs_rsp_data,            64'h1234);
        chk("rd_err",     64'(obs_rsp_err),        64'h0);
        chk("rd_pulses",  64'(obs_rd_n),           64'd1);

        // Write: pulse carries addr/data, response after the settle gap.
        obs_clear(); a_c = cyc;
        tick(1'b1, 1'b1, 17'h08000, 64'hA5, 1'b0, 64'h0);
        idle(WR_GAP + 4);
        chk("wr_pulse_cyc", 64'(obs_en_first - a_c), 64'd1);
        chk("wr_addr",      64'(obs_en_addr),        64'h08000);
        chk("wr_wdata",     obs_en_data,             64'hA5);
        chk("wr_latency",   64'(obs_rsp_cyc - a_c),  64'd10);
        chk("wr_rsp_data",  obs_rsp_data,            64'h0);
        chk("wr_pulses",    64'(obs_wr_n),           64'd1);

        // Read timeout, then a late return that must be ignored.
        do_reset();
        obs_clear(); a_c = cyc;
        tick(1'b1, 1'b0, 17'h1ABCD, 64'h0, 1'b0, 64'h0);
        idle(TIMEOUT + 3);
        tick(1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h77);
        idle(2);
        chk("to_latency", 64'(obs_rsp_cyc - a_c), 64'd34);
        chk("to_data",    obs_rsp_data,            64'hDEAD_0000_0001_ABCD);
        chk("to_err",     64'(obs_rsp_err),        64'h1);
        chk("to_rsp_n",   64'(obs_rsp_n),          64'd1);
`ifdef BIST_MM_ERR_LOG_EN
        chk("log_to_cnt",    64'(bus.oERR_TO_CNT),    64'd1);
        chk("log_stray_cnt", 64'(bus.oERR_STRAY_CNT), 64'd1);
        chk("log_last_addr", 64'(bus.oERR_LAST_ADDR), 64'h1ABCD);
`endif

        // Data arriving in the exact timeout cycle wins.
        obs_clear(); a_c = cyc;
        tick(1'b1, 1'b0, 17'h00321, 64'h0, 1'b0, 64'h0);
        idle(TIMEOUT);
        tick(1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'hCAFE);
        idle(3);
        chk("edge_latency", 64'(obs_rsp_cyc - a_c), 64'd34);
        chk("edge_data",    obs_rsp_data,            64'hCAFE);
        chk("edge_err",     64'(obs_rsp_err),        64'h0);

        // Back-to-back writes with REQ_V held high.
        obs_clear(); a_c = cyc;
        for (int i = 0; i < 14; i++) tick(1'b1, 1'b1, 17'($urandom), {$urandom, $urandom}, 1'b0, 64'h0);
        idle(WR_GAP + 4);
        chk("b2b_pulses",  64'(obs_wr_n),                  64'd2);
        chk("b2b_first",   64'(obs_en_first - a_c),        64'd1);
        chk("b2b_spacing", 64'(obs_en_last - obs_en_first), 64'd11);

        // Reset while waiting for read data abandons the request.
        tick(1'b1, 1'b0, 17'h00AAA, 64'h0, 1'b0, 64'h0);
        idle(3);
        obs_clear();
        rst = 1'b1;
        tick(1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h5);
        idle(1);
        rst = 1'b0;
        tick(1'b0, 1'b0, 17'h0, 64'h0, 1'b1, 64'h6);
        idle(TIMEOUT + 4);
        chk("rst_no_rsp",  64'(obs_rsp_n),          64'd0);
        chk("rst_rdy",     64'(bus.oHOST_REQ_RDY),  64'h1);

        random_phase(1500, 6);
        random_phase(1500, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
